// File: rtl/factorial_pkg.sv
// Shared definitions for the factorial host and controller side.
// Contents:
//   - default operand/result widths and done timeout
//   - sequencer state encoding
package factorial_pkg;

  localparam int XW_DEF  = 4;
  localparam int RW_DEF  = 32;
  localparam int TMO_DEF = 255;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2,
    RESP    = 2'd3
  } fac_state_e;

endpackage : factorial_pkg

// File: rtl/factorial_host_if.sv
// Request/response handshake bundle between a command source and the
// factorial host.
//   master : command source (drives req_valid/req_x/rsp_ready)
//   slave  : factorial host (drives req_ready/rsp_valid/rsp_result/rsp_err)
interface factorial_host_if #(
  parameter int XW = 4,
  parameter int RW = 32
);

  logic          req_valid;
  logic          req_ready;
  logic [XW-1:0] req_x;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [RW-1:0] rsp_result;
  logic          rsp_err;

  modport master (
    output req_valid, req_x, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_err
  );

  modport slave (
    input  req_valid, req_x, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_err
  );

endinterface : factorial_host_if

// File: rtl/fac_wdog.sv
// Saturating wait counter guarding the factorial unit's done response.
// Ports:
//   CLK, RST_N : clock, asynchronous active-low reset
//   clr        : restart the count at zero (wins over en)
//   en         : count this cycle
//   expired    : the count has reached TMO, counting the current enabled
//                cycle, so the caller can act on the TMO-th counted edge
module fac_wdog #(
  parameter int TMO = 255,
  parameter int CW  = $clog2(TMO + 1)
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [CW-1:0] TMO_C  = CW'(TMO);
  localparam logic [CW-1:0] LAST_C = CW'(TMO - 1);

  logic [CW-1:0] cnt_r;

  // Count register: clear, saturating increment at TMO, hold otherwise.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_r <= {CW{1'b0}};
    end else if (clr) begin
      cnt_r <= {CW{1'b0}};
    end else if (en && (cnt_r != TMO_C)) begin
      cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Expiry looks one increment ahead so the limit edge itself triggers it.
  always_comb begin
    expired = (cnt_r == TMO_C) || (en && (cnt_r == LAST_C));
  end

endmodule : fac_wdog

// File: rtl/factorial_host.sv
// Requester-side sequencer for the factorial unit.
// Ports:
//   CLK, RST_N           : clock, asynchronous active-low reset
//   bus (slave)          : request (req_valid/req_ready/req_x) and response
//                          (rsp_valid/rsp_ready/rsp_result/rsp_err) handshakes
//   fac_start, fac_x     : registered start/operand to the unit
//   fac_done, fac_result : unit done level and result
//   jobs_done            : completed response count, wraps at 256
// A job is issued, held until done (or timeout), then start is released and
// the host waits for done to fall before presenting the response, so the
// unit is always back in idle before the next start.
module factorial_host
  import factorial_pkg::*;
#(
  parameter int XW  = XW_DEF,
  parameter int RW  = RW_DEF,
  parameter int TMO = TMO_DEF
) (
  input  logic                CLK,
  input  logic                RST_N,
  factorial_host_if.slave     bus,
  output logic                fac_start,
  output logic [XW-1:0]       fac_x,
  input  logic                fac_done,
  input  logic [RW-1:0]       fac_result,
  output logic [7:0]          jobs_done
);

  fac_state_e    state_r;
  fac_state_e    next_state_s;
  logic          fac_start_r;
  logic [XW-1:0] fac_x_r;
  logic          rsp_valid_r;
  logic [RW-1:0] rsp_result_r;
  logic          rsp_err_r;
  logic [7:0]    jobs_done_r;
  logic          wdog_clr_s;
  logic          wdog_en_s;
  logic          expired_s;

  fac_wdog #(
    .TMO (TMO)
  ) u_wdog (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .clr     (wdog_clr_s),
    .en      (wdog_en_s),
    .expired (expired_s)
  );

  // Watchdog control: restart on acceptance, count only while issuing.
  always_comb begin
    wdog_clr_s = (state_r == IDLE) && bus.req_valid;
    wdog_en_s  = (state_r == ISSUE);
  end

  // Next-state decode; done takes priority over a coincident timeout.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.req_valid) next_state_s = ISSUE;
        else               next_state_s = IDLE;
      end
      ISSUE: begin
        if (fac_done || expired_s) next_state_s = RELEASE;
        else                       next_state_s = ISSUE;
      end
      RELEASE: begin
        if (!fac_done) next_state_s = RESP;
        else           next_state_s = RELEASE;
      end
      RESP: begin
        if (bus.rsp_ready) next_state_s = IDLE;
        else               next_state_s = RESP;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r      <= IDLE;
      fac_start_r  <= 1'b0;
      fac_x_r      <= {XW{1'b0}};
      rsp_valid_r  <= 1'b0;
      rsp_result_r <= {RW{1'b0}};
      rsp_err_r    <= 1'b0;
      jobs_done_r  <= 8'd0;
    end else begin
      state_r <= next_state_s;
      case (state_r)
        IDLE: begin
          if (bus.req_valid) begin
            fac_x_r     <= bus.req_x;
            fac_start_r <= 1'b1;
          end
        end
        ISSUE: begin
          if (fac_done) begin
            rsp_result_r <= fac_result;
            rsp_err_r    <= 1'b0;
            fac_start_r  <= 1'b0;
          end else if (expired_s) begin
            rsp_result_r <= {RW{1'b0}};
            rsp_err_r    <= 1'b1;
            fac_start_r  <= 1'b0;
          end
        end
        RELEASE: begin
          if (!fac_done) rsp_valid_r <= 1'b1;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
            jobs_done_r <= jobs_done_r + 8'd1;
          end
        end
        default: begin
          fac_start_r <= 1'b0;
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready  = (state_r == IDLE);
  assign bus.rsp_valid  = rsp_valid_r;
  assign bus.rsp_result = rsp_result_r;
  assign bus.rsp_err    = rsp_err_r;
  assign fac_start      = fac_start_r;
  assign fac_x          = fac_x_r;
  assign jobs_done      = jobs_done_r;

endmodule : factorial_host

// File: tb/tb_factorial_host.sv
// Self-checking bench for factorial_host with a behavioural factorial unit
// (start/done handshake, done held until start drops, configurable latency).
module tb_factorial_host;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        fac_start;
  logic [3:0]  fac_x;
  logic        fac_done;
  logic [31:0] fac_result;
  logic [7:0]  jobs_done;

  factorial_host_if #(.XW(4), .RW(32)) bus ();

  factorial_host #(.XW(4), .RW(32), .TMO(255)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .bus        (bus),
    .fac_start  (fac_start),
    .fac_x      (fac_x),
    .fac_done   (fac_done),
    .fac_result (fac_result),
    .jobs_done  (jobs_done)
  );

  always #5 CLK = ~CLK;

  // Behavioural unit
  int lat   = 1;
  bit never = 1'b0;
  int ucnt;

  function automatic logic [31:0] fact(input logic [3:0] n);
    logic [31:0] f = 32'd1;
    for (int i = 2; i <= int'(n); i++) f = f * 32'(i);
    return f;
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fac_done   <= 1'b0;
      fac_result <= 32'd0;
      ucnt       <= 0;
    end else if (!fac_start) begin
      fac_done <= 1'b0;
      ucnt     <= 0;
    end else if (!fac_done && !never) begin
      if (ucnt == lat - 1) begin
        fac_done   <= 1'b1;
        fac_result <= fact(fac_x);
      end else begin
        ucnt <= ucnt + 1;
      end
    end
  end

  // Handshake monitors
  int  start_cycles;
  int  overlap_cycles;
  int  start_in_done;
  logic prev_start = 1'b0;
  always @(negedge CLK) begin
    if (fac_start) start_cycles++;
    if (fac_start && fac_done) overlap_cycles++;
    if (fac_start && !prev_start && fac_done) start_in_done++;
    prev_start = fac_start;
  end

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [7:0] jobs_exp = 8'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%0d required=%0d", name, act, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_fac_start"},  64'(fac_start),      64'd0);
    check({tag, "_fac_x"},      64'(fac_x),          64'd0);
    check({tag, "_rsp_valid"},  64'(bus.rsp_valid),  64'd0);
    check({tag, "_rsp_result"}, 64'(bus.rsp_result), 64'd0);
    check({tag, "_rsp_err"},    64'(bus.rsp_err),    64'd0);
    check({tag, "_jobs_done"},  64'(jobs_done),      64'd0);
    check({tag, "_req_ready"},  64'(bus.req_ready),  64'd1);
  endtask

  // Issue one request and collect its response with rsp_ready high.
  task automatic run_job(input logic [3:0] x, output logic [31:0] res, output logic err);
    int n;
    res = 32'd0;
    err = 1'b0;
    @(negedge CLK);
    n = 0;
    while (!bus.req_ready && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (!bus.req_ready) check("req_ready_wait", 64'd0, 64'd1);
    start_cycles   = 0;
    overlap_cycles = 0;
    bus.req_valid  = 1'b1;
    bus.req_x      = x;
    bus.rsp_ready  = 1'b1;
    @(negedge CLK);
    bus.req_valid  = 1'b0;
    bus.req_x      = 4'd15;
    n = 0;
    while (!bus.rsp_valid && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    if (!bus.rsp_valid) begin
      check("rsp_valid_wait", 64'd0, 64'd1);
    end else begin
      res = bus.rsp_result;
      err = bus.rsp_err;
      jobs_exp = jobs_exp + 8'd1;
      @(negedge CLK);
      check("post_handshake_req_ready", 64'(bus.req_ready), 64'd1);
      check("post_handshake_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    end
    bus.rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  x;
    int          latency;
    logic [31:0] exp_result;
  } vec_t;

  vec_t vecs [9];
  logic [31:0] res;
  logic        err;

  initial begin
    vecs[0] = '{4'd5,  20, 32'd120};
    vecs[1] = '{4'd10,  3, 32'd3628800};
    vecs[2] = '{4'd0,   2, 32'd1};
    vecs[3] = '{4'd1,   1, 32'd1};
    vecs[4] = '{4'd7,   5, 32'd5040};
    vecs[5] = '{4'd12,  4, 32'd479001600};
    vecs[6] = '{4'd13,  2, 32'd1932053504};
    vecs[7] = '{4'd3,   1, 32'd6};
    vecs[8] = '{4'd4,   1, 32'd24};

    bus.req_valid = 1'b0;
    bus.req_x     = 4'd0;
    bus.rsp_ready = 1'b0;
    start_in_done = 0;

    #12;
    check_reset_outputs("reset");
    @(negedge CLK);
    RST_N = 1'b1;

    // Table-driven jobs; the last two run back-to-back.
    for (int i = 0; i < 9; i++) begin
      lat = vecs[i].latency;
      run_job(vecs[i].x, res, err);
      check($sformatf("vec%0d_result", i), 64'(res), 64'(vecs[i].exp_result));
      check($sformatf("vec%0d_err", i), 64'(err), 64'd0);
      check($sformatf("vec%0d_start_cycles", i), 64'(start_cycles), 64'(vecs[i].latency + 1));
      check($sformatf("vec%0d_overlap", i), 64'(overlap_cycles), 64'd1);
      check($sformatf("vec%0d_jobs_done", i), 64'(jobs_done), 64'(jobs_exp));
    end

    // Unit never answers: timeout after 255 ISSUE cycles.
    never = 1'b1;
    run_job(4'd6, res, err);
    check("tmo_err", 64'(err), 64'd1);
    check("tmo_result", 64'(res), 64'd0);
    check("tmo_start_cycles", 64'(start_cycles), 64'd255);
    check("tmo_jobs_done", 64'(jobs_done), 64'(jobs_exp));
    never = 1'b0;

    // Consumer stalls for 10 cycles after x=4.
    lat = 3;
    @(negedge CLK);
    bus.req_valid = 1'b1;
    bus.req_x     = 4'd4;
    @(negedge CLK);
    bus.req_valid = 1'b0;
    for (int n = 0; n < 100 && !bus.rsp_valid; n++) @(negedge CLK);
    check("stall_rsp_valid_seen", 64'(bus.rsp_valid), 64'd1);
    bus.req_valid = 1'b1;
    bus.req_x     = 4'd9;
    for (int n = 0; n < 10; n++) begin
      @(negedge CLK);
      check("stall_rsp_valid", 64'(bus.rsp_valid), 64'd1);
      check("stall_rsp_result", 64'(bus.rsp_result), 64'd24);
      check("stall_req_ready", 64'(bus.req_ready), 64'd0);
      check("stall_fac_start", 64'(fac_start), 64'd0);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    jobs_exp = jobs_exp + 8'd1;
    @(negedge CLK);
    bus.rsp_ready = 1'b0;
    check("stall_jobs_done", 64'(jobs_done), 64'(jobs_exp));
    check("stall_req_ready_after", 64'(bus.req_ready), 64'd1);

    // Reset in the middle of ISSUE.
    lat = 20;
    bus.req_valid = 1'b1;
    bus.req_x     = 4'd6;
    @(negedge CLK);
    bus.req_valid = 1'b0;
    repeat (5) @(negedge CLK);
    check("midrst_start_before", 64'(fac_start), 64'd1);
    #2 RST_N = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge CLK);
    RST_N = 1'b1;
    jobs_exp = 8'd0;
    lat = 2;
    run_job(4'd2, res, err);
    check("after_rst_result", 64'(res), 64'd2);
    check("after_rst_err", 64'(err), 64'd0);
    check("after_rst_jobs_done", 64'(jobs_done), 64'd1);

    // Counter wrap: bring jobs_done to 255, then one more wraps to 0.
    lat = 1;
    for (int j = 0; j < 254; j++) run_job(4'(j % 8), res, err);
    check("wrap_jobs_255", 64'(jobs_done), 64'd255);
    run_job(4'd6, res, err);
    check("wrap_result", 64'(res), 64'd720);
    check("wrap_jobs_0", 64'(jobs_done), 64'd0);

    check("no_start_while_done", 64'(start_in_done), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Absolute time bound.
  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time bound exceeded");
  end

endmodule : tb_factorial_host
